// File: rtl/lsm_decision_poly.sv
// lsm_decision_poly
//
// Per-path exercise/hold decision for one time step of the Longstaff-Schwartz
// backward sweep. The continuation value C = sum beta[i]*S^i is evaluated by
// Horner's rule with one saturating multiply per cycle. C is then compared with
// the immediate payoff, and the updated path cash-flow is emitted: the payoff
// if exercised, otherwise the discounted cash-flow from t+1.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   path handshake (ready only while idle)
//   s_t, cf_next          price at t, undiscounted cash-flow at t+1
//   beta                  NBASIS packed coefficients, beta[i] = [i*WIDTH +: WIDTH]
//   strike, disc          strike K, one-step discount factor
//   out_valid / out_ready result handshake
//   pv_out, exercised     updated cash-flow, exercise flag
//   out_sat               any saturation seen while processing this path
//
// Optional feature: define LSM_DEC_OTM_BYPASS_EN so that out-of-the-money paths
// (payoff 0) skip the Horner evaluation and go straight to the decision.
module lsm_decision_poly #(
  parameter int WIDTH   = 32,
  parameter int QFRAC   = 16,
  parameter int NBASIS  = 3,
  parameter int IS_CALL = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] s_t,
  input  logic signed [WIDTH-1:0] cf_next,
  input  logic [NBASIS*WIDTH-1:0] beta,
  input  logic signed [WIDTH-1:0] strike,
  input  logic signed [WIDTH-1:0] disc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] pv_out,
  output logic                    exercised,
  output logic                    out_sat
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HORNER = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Index of the final Horner step (unused when NBASIS == 1).
  localparam logic [2:0] LAST = 3'(NBASIS - 2);

  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  // Fixed-point multiply: full-width product, floor shift, clamp.
  // Returns {saturated, value}.
  function automatic logic [WIDTH:0] sat_mul(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    logic signed [2*WIDTH-1:0] hi;
    logic signed [2*WIDTH-1:0] lo;
    hi = {{WIDTH{1'b0}}, MAXV};
    lo = {{WIDTH{1'b1}}, MINV};
    p  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    p  = p >>> QFRAC;
    if (p > hi) return {1'b1, MAXV};
    if (p < lo) return {1'b1, MINV};
    return {1'b0, p[WIDTH-1:0]};
  endfunction

  // Saturating add/subtract. Returns {saturated, value}.
  function automatic logic [WIDTH:0] sat_add(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b,
                                             input logic                    sub);
    logic signed [WIDTH:0] s;
    s = sub ? ((WIDTH+1)'(a) - (WIDTH+1)'(b)) : ((WIDTH+1)'(a) + (WIDTH+1)'(b));
    if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? MINV : MAXV)};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  logic [1:0]                state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic signed [WIDTH-1:0]   acc_q, acc_d;
  logic signed [WIDTH-1:0]   payoff_q, payoff_d;
  logic signed [WIDTH-1:0]   s_q, s_d;
  logic signed [WIDTH-1:0]   cf_q, cf_d;
  logic signed [WIDTH-1:0]   disc_q, disc_d;
  logic [NBASIS*WIDTH-1:0]   beta_q, beta_d;
  logic                      sat_q, sat_d;
  logic signed [WIDTH-1:0]   pv_q, pv_d;
  logic                      ex_q, ex_d;
  logic                      osat_q, osat_d;
  logic                      ovld_q, ovld_d;

  logic signed [WIDTH-1:0]   diff, pay_new, prod, sum, dcf;
  logic                      f_diff, f_prod, f_sum, f_dcf;
  logic [2:0]                bidx;
  logic                      exercise;

  // Intrinsic value of the offered sample; a negative difference means OTM.
  assign {f_diff, diff} = sat_add((IS_CALL != 0) ? s_t : strike,
                                  (IS_CALL != 0) ? strike : s_t, 1'b1);
  assign pay_new = diff[WIDTH-1] ? '0 : diff;

  // Horner step j consumes beta[NBASIS-2-j].
  assign bidx = LAST - cnt_q;
  assign {f_prod, prod} = sat_mul(acc_q, s_q);
  assign {f_sum, sum}   = sat_add(prod, beta_q[int'(bidx)*WIDTH +: WIDTH], 1'b0);

  assign {f_dcf, dcf} = sat_mul(cf_q, disc_q);

  // Ties go to exercise; a zero payoff never exercises, whatever C is.
  assign exercise = (payoff_q != '0) && (payoff_q >= acc_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    payoff_d = payoff_q;
    s_d      = s_q;
    cf_d     = cf_q;
    disc_d   = disc_q;
    beta_d   = beta_q;
    sat_d    = sat_q;
    pv_d     = pv_q;
    ex_d     = ex_q;
    osat_d   = osat_q;
    ovld_d   = ovld_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s_d      = s_t;
          cf_d     = cf_next;
          disc_d   = disc;
          beta_d   = beta;
          acc_d    = beta[(NBASIS-1)*WIDTH +: WIDTH];
          payoff_d = pay_new;
          sat_d    = f_diff;
          cnt_d    = '0;
          state_d  = (NBASIS == 1) ? ST_DECIDE : ST_HORNER;
`ifdef LSM_DEC_OTM_BYPASS_EN
          // OTM paths can never exercise, so the continuation value is moot.
          if (pay_new == '0) begin
            state_d = ST_DECIDE;
            acc_d   = acc_q;
          end
`endif
        end
      end
      ST_HORNER: begin
        acc_d = sum;
        sat_d = sat_q | f_prod | f_sum;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        ex_d    = exercise;
        pv_d    = exercise ? payoff_q : dcf;
        // Discount saturation only matters when the discounted value is emitted.
        osat_d  = sat_q | (!exercise && f_dcf);
        ovld_d  = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      pv_q    <= '0;
      ex_q    <= 1'b0;
      osat_q  <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pv_q    <= pv_d;
      ex_q    <= ex_d;
      osat_q  <= osat_d;
      ovld_q  <= ovld_d;
    end
  end

  // Path operands are always loaded before use, so they need no reset.
  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    payoff_q <= payoff_d;
    s_q      <= s_d;
    cf_q     <= cf_d;
    disc_q   <= disc_d;
    beta_q   <= beta_d;
    sat_q    <= sat_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = ovld_q;
  assign pv_out    = pv_q;
  assign exercised = ex_q;
  assign out_sat   = osat_q;

endmodule

// File: tb/tb_lsm_decision_poly.sv
// Testbench for lsm_decision_poly: directed Q16.16 cases, backpressure,
// mid-operation reset and randomized paths against a behavioural model.
module tb_lsm_decision_poly;
  localparam int WIDTH = 32, QFRAC = 16, NBASIS = 3, IS_CALL = 0;
`ifdef LSM_DEC_OTM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [WIDTH-1:0] s_t = '0, cf_next = '0, strike = '0, disc = '0;
  logic [NBASIS*WIDTH-1:0] beta_bus = '0;
  logic out_valid;
  logic out_ready;
  logic signed [WIDTH-1:0] pv_out;
  logic exercised, out_sat;

  lsm_decision_poly #(.WIDTH(WIDTH), .QFRAC(QFRAC), .NBASIS(NBASIS), .IS_CALL(IS_CALL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s_t(s_t), .cf_next(cf_next), .beta(beta_bus), .strike(strike), .disc(disc),
    .out_valid(out_valid), .out_ready(out_ready), .pv_out(pv_out),
    .exercised(exercised), .out_sat(out_sat));

  always #5 clk = ~clk;

  typedef struct { int pv; bit ex; bit sat; int lat; longint acc_cyc; } exp_t;
  exp_t expq[$];
  int n_cmp = 0, n_fail = 0;
  longint cyc = 0;
  int stall_len = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int clampq(input longint v, inout bit f);
    longint maxl = 64'sd2147483647;
    longint minl = -64'sd2147483648;
    if (v > maxl) begin f = 1'b1; return int'(maxl); end
    if (v < minl) begin f = 1'b1; return int'(minl); end
    return int'(v);
  endfunction

  // Reference: payoff, saturating Horner polynomial, decision, discounting.
  function automatic exp_t model(input int s, input int k, input int cf, input int d,
                                 input int b[NBASIS]);
    exp_t e;
    longint c;
    int p, dv;
    bit f, fd;
    f = 1'b0; fd = 1'b0;
    p = clampq(IS_CALL != 0 ? longint'(s) - longint'(k) : longint'(k) - longint'(s), f);
    if (p < 0) p = 0;
    dv = clampq((longint'(cf) * longint'(d)) >>> QFRAC, fd);
    e.acc_cyc = 0;
    if (BYPASS && p == 0) begin
      e.ex = 1'b0; e.pv = dv; e.sat = f | fd; e.lat = 1;
      return e;
    end
    c = b[NBASIS-1];
    for (int i = NBASIS-2; i >= 0; i--)
      c = clampq(longint'(clampq((c * longint'(s)) >>> QFRAC, f)) + longint'(b[i]), f);
    e.ex  = (p > 0) && (longint'(p) >= c);
    e.pv  = e.ex ? p : dv;
    e.sat = f | (!e.ex & fd);
    e.lat = NBASIS;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer: optionally stalls stall_len cycles once a result appears.
  initial begin
    int hc;
    hc = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (hc < stall_len) begin out_ready = 1'b0; hc++; end
        else out_ready = 1'b1;
      end else begin
        hc = 0;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Compare process: every result cycle is checked against the queued model value.
  initial begin
    exp_t e, cur;
    bit was_v;
    was_v = 1'b0;
    cur = '{pv: 0, ex: 1'b0, sat: 1'b0, lat: 0, acc_cyc: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) was_v = 1'b0;
      else if (out_valid) begin
        chk("in_ready_while_busy", in_ready, 0);
        if (!was_v) begin
          if (expq.size() == 0) chk("unexpected_out_valid", out_valid, 0);
          else begin
            e = expq.pop_front();
            cur = e;
            chk("latency", cyc - e.acc_cyc, e.lat);
            chk("pv_out", pv_out, e.pv);
            chk("exercised", exercised, e.ex);
            chk("out_sat", out_sat, e.sat);
          end
        end else begin
          chk("pv_stable", pv_out, cur.pv);
          chk("ex_stable", exercised, cur.ex);
          chk("sat_stable", out_sat, cur.sat);
        end
        was_v = 1'b1;
      end else was_v = 1'b0;
    end
  end

  task automatic drive_path(input int s, input int k, input int cf, input int d,
                            input int b[NBASIS], input bit expect_it);
    exp_t e;
    int w;
    @(negedge clk);
    s_t = s; strike = k; cf_next = cf; disc = d;
    for (int i = 0; i < NBASIS; i++) beta_bus[i*WIDTH +: WIDTH] = b[i];
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 300) begin @(negedge clk); w++; end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    if (expect_it) begin
      e = model(s, k, cf, d, b);
      e.acc_cyc = cyc + 1;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    // After acceptance the inputs must be ignored: scramble them.
    in_valid = 1'b0;
    s_t = $urandom; strike = $urandom; cf_next = $urandom; disc = $urandom;
    for (int i = 0; i < NBASIS; i++) beta_bus[i*WIDTH +: WIDTH] = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((expq.size() != 0 || out_valid) && w < 500) begin @(negedge clk); w++; end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
  endtask

  function automatic int rq(input int range_int);
    return int'($urandom_range(0, 2*range_int*65536 - 1)) - range_int*65536;
  endfunction

  task automatic random_path();
    int b[NBASIS];
    bit wide;
    wide = ($urandom_range(0, 7) == 0);
    for (int i = 0; i < NBASIS; i++) b[i] = wide ? int'($urandom) : rq(4);
    drive_path(wide ? int'($urandom) : rq(16), rq(16), rq(16),
               int'($urandom_range(0, 32'h10000)), b, 1'b1);
  endtask

  initial begin
    exp_t e;
    int b1[NBASIS], b4[NBASIS], bt[NBASIS], bn[NBASIS];
    b1 = '{32'h10000, 32'h8000, 0};
    b4 = '{0, 0, 32'h7FFF0000};
    bt = '{32'h20000, 0, 0};
    bn = '{-32'sh10000, 0, 0};

    // Pin the model with hand-computed values.
    e = model(32'h20000, 32'h50000, 32'h10000, 32'h10000, b1);
    chk("pin_ex_pv", e.pv, 32'h30000); chk("pin_ex_flag", e.ex, 1); chk("pin_ex_lat", e.lat, 3);
    e = model(32'h20000, 32'h28000, 32'h40000, 32'h8000, b1);
    chk("pin_hold_pv", e.pv, 32'h20000); chk("pin_hold_flag", e.ex, 0);
    e = model(32'h60000, 32'h50000, 32'h20000, 32'hC000, b1);
    chk("pin_otm_pv", e.pv, 32'h18000); chk("pin_otm_lat", e.lat, BYPASS ? 1 : 3);
    e = model(32'hC80000, 32'h75300000, 32'h10000, 32'h8000, b4);
    chk("pin_sat_flag", e.sat, 1); chk("pin_sat_pv", e.pv, 32'h8000); chk("pin_sat_ex", e.ex, 0);
    e = model(32'h10000, 32'h30000, 32'h10000, 32'h10000, bt);
    chk("pin_tie_ex", e.ex, 1); chk("pin_tie_pv", e.pv, 32'h20000);
    e = model(32'h50000, 32'h50000, 32'h10000, 32'h8000, bn);
    chk("pin_zero_pay_ex", e.ex, 0); chk("pin_zero_pay_pv", e.pv, 32'h8000);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0); chk("rst_pv", pv_out, 0);
    chk("rst_ex", exercised, 0); chk("rst_sat", out_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Directed cases.
    drive_path(32'h20000, 32'h50000, 32'h10000, 32'h10000, b1, 1'b1); drain();
    drive_path(32'h20000, 32'h28000, 32'h40000, 32'h8000, b1, 1'b1); drain();
    drive_path(32'h60000, 32'h50000, 32'h20000, 32'hC000, b1, 1'b1); drain();
    drive_path(32'hC80000, 32'h75300000, 32'h10000, 32'h8000, b4, 1'b1); drain();
    drive_path(32'h10000, 32'h30000, 32'h10000, 32'h10000, bt, 1'b1); drain();
    drive_path(32'h50000, 32'h50000, 32'h10000, 32'h8000, bn, 1'b1); drain();

    // Backpressure with the next path already offered.
    stall_len = 5;
    drive_path(32'h20000, 32'h50000, 32'h10000, 32'h10000, b1, 1'b1);
    drive_path(32'h20000, 32'h28000, 32'h40000, 32'h8000, b1, 1'b1);
    drain();
    stall_len = 0;

    // Reset during HORNER: path dropped, outputs cleared.
    drive_path(32'h20000, 32'h50000, 32'h10000, 32'h10000, b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0); chk("midrst_pv", pv_out, 0);
    chk("midrst_ex", exercised, 0); chk("midrst_sat", out_sat, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    repeat (10) random_path();
    drain();

    // Randomized paths with random consumer stalls.
    for (int n = 0; n < 150; n++) begin
      stall_len = int'($urandom_range(0, 3));
      random_path();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
